// File: rtl/mini_processor.sv
// Single-cycle 4-bit processor with five registers (r0..r4) and zero/carry flags.
// One 8-bit instruction is decoded and executed per clock when sig_valid is high.
module mini_processor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sig,
  input  logic       sig_valid,
  output logic [3:0] r0,
  output logic [3:0] r1,
  output logic [3:0] r2,
  output logic [3:0] r3,
  output logic [3:0] r4,
  output logic       zero,
  output logic       carry
);

  typedef enum logic [1:0] {
    OP_MOVI = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } opcode_t;

  opcode_t    op;
  logic [2:0] rd;
  logic [2:0] rs_imm;
  logic [3:0] src_val;
  logic [3:0] dst_val;
  logic [4:0] sum5;
  logic [4:0] diff5;
  logic [3:0] result;
  logic       next_carry;

  assign op     = opcode_t'(sig[7:6]);
  assign rd     = sig[5:3];
  assign rs_imm = sig[2:0];

  // Register reads; indices 5..7 read as zero.
  always_comb begin
    src_val = 4'd0;
    case (rs_imm)
      3'd0:    src_val = r0;
      3'd1:    src_val = r1;
      3'd2:    src_val = r2;
      3'd3:    src_val = r3;
      3'd4:    src_val = r4;
      default: src_val = 4'd0;
    endcase
  end

  always_comb begin
    dst_val = 4'd0;
    case (rd)
      3'd0:    dst_val = r0;
      3'd1:    dst_val = r1;
      3'd2:    dst_val = r2;
      3'd3:    dst_val = r3;
      3'd4:    dst_val = r4;
      default: dst_val = 4'd0;
    endcase
  end

  // Zero-extended 5-bit ops: bit 4 is carry-out for ADD and borrow for SUB.
  assign sum5  = {1'b0, dst_val} + {1'b0, src_val};
  assign diff5 = {1'b0, dst_val} - {1'b0, src_val};

  always_comb begin
    result     = 4'd0;
    next_carry = carry;
    case (op)
      OP_MOVI: result = {1'b0, rs_imm};
      OP_MOV:  result = src_val;
      OP_ADD: begin
        result     = sum5[3:0];
        next_carry = sum5[4];
      end
      OP_SUB: begin
        result     = diff5[3:0];
        next_carry = diff5[4];
      end
      default: result = 4'd0;
    endcase
  end

  // Only rd is written; writes to 5..7 are dropped but flags still update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0    <= 4'd0;
      r1    <= 4'd1;
      r2    <= 4'd2;
      r3    <= 4'd3;
      r4    <= 4'd4;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (sig_valid) begin
      case (rd)
        3'd0:    r0 <= result;
        3'd1:    r1 <= result;
        3'd2:    r2 <= result;
        3'd3:    r3 <= result;
        3'd4:    r4 <= result;
        default: ;
      endcase
      zero  <= (result == 4'd0);
      carry <= next_carry;
    end
  end

endmodule

// File: tb/tb_mini_processor.sv
// Directed self-checking bench for mini_processor; expected register images are
// hand-computed and packed as {r4,r3,r2,r1,r0}.
module tb_mini_processor;

  logic       clk;
  logic       rst_n;
  logic [7:0] sig;
  logic       sig_valid;
  logic [3:0] r0, r1, r2, r3, r4;
  logic       zero;
  logic       carry;
  logic [19:0] regs;

  int checks;
  int failures;

  mini_processor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig      (sig),
    .sig_valid(sig_valid),
    .r0       (r0),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3),
    .r4       (r4),
    .zero     (zero),
    .carry    (carry)
  );

  assign regs = {r4, r3, r2, r1, r0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs away from the edge, then sample just after it.
  task automatic exec(input logic [7:0] instr, input logic v, input logic rn);
    @(negedge clk);
    sig       = instr;
    sig_valid = v;
    rst_n     = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exec(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) exec(8'h00, 1'b0, 1'b1);
      else begin
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
      checks++;
      if (regs !== 20'h43210) begin
        failures++;
        $display("[TB] FAIL reset_regs cycle %0d: got %h expected %h", i, regs, 20'h43210);
      end
      checks++;
      if ({zero, carry} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL reset_flags cycle %0d: got z=%b c=%b expected z=0 c=0", i, zero, carry);
      end
    end
  endtask

  task automatic test_sequence;
    logic [7:0]  instr [4];
    logic [19:0] exp_regs [4];
    logic [1:0]  exp_flags [4];
    instr = '{8'h93, 8'hA1, 8'h10, 8'hC8};
    exp_regs = '{20'h43510, 20'h53510, 20'h53010, 20'h53010};
    exp_flags = '{2'b00, 2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      exec(instr[i], 1'b1, 1'b1);
      checks++;
      if (regs !== exp_regs[i] || {zero, carry} !== exp_flags[i]) begin
        failures++;
        $display("[TB] FAIL sequence step %0d (sig=%h): got regs=%h zc=%b expected regs=%h zc=%b",
                 i, instr[i], regs, {zero, carry}, exp_regs[i], exp_flags[i]);
      end
    end
  endtask

  task automatic test_wrap_borrow;
    logic [7:0]  instr [4];
    logic [19:0] exp_regs [4];
    logic [1:0]  exp_flags [4];
    instr = '{8'h07, 8'h80, 8'h80, 8'hC8};
    exp_regs = '{20'h53017, 20'h5301E, 20'h5301C, 20'h5305C};
    exp_flags = '{2'b00, 2'b00, 2'b01, 2'b01};
    for (int i = 0; i < 4; i++) begin
      exec(instr[i], 1'b1, 1'b1);
      checks++;
      if (regs !== exp_regs[i] || {zero, carry} !== exp_flags[i]) begin
        failures++;
        $display("[TB] FAIL wrap_borrow step %0d (sig=%h): got regs=%h zc=%b expected regs=%h zc=%b",
                 i, instr[i], regs, {zero, carry}, exp_regs[i], exp_flags[i]);
      end
    end
  endtask

  task automatic test_out_of_range;
    logic [7:0]  instr [4];
    logic [19:0] exp_regs [4];
    logic [1:0]  exp_flags [4];
    // MOV r3,r6 ; MOVI r7,5 ; ADD r5,r0 ; SUB r0,r7
    instr = '{8'h5E, 8'h3D, 8'hA8, 8'hC7};
    exp_regs = '{20'h5005C, 20'h5005C, 20'h5005C, 20'h5005C};
    exp_flags = '{2'b11, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 4; i++) begin
      exec(instr[i], 1'b1, 1'b1);
      checks++;
      if (regs !== exp_regs[i] || {zero, carry} !== exp_flags[i]) begin
        failures++;
        $display("[TB] FAIL out_of_range step %0d (sig=%h): got regs=%h zc=%b expected regs=%h zc=%b",
                 i, instr[i], regs, {zero, carry}, exp_regs[i], exp_flags[i]);
      end
    end
  endtask

  task automatic test_valid_and_reset;
    exec(8'h93, 1'b0, 1'b1);
    checks++;
    if (regs !== 20'h5005C || {zero, carry} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL valid_gating: got regs=%h zc=%b expected regs=%h zc=%b",
               regs, {zero, carry}, 20'h5005C, 2'b00);
    end
    exec(8'h93, 1'b1, 1'b0);
    checks++;
    if (regs !== 20'h43210 || {zero, carry} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_priority: got regs=%h zc=%b expected regs=%h zc=%b",
               regs, {zero, carry}, 20'h43210, 2'b00);
    end
    exec(8'h93, 1'b1, 1'b1);
    checks++;
    if (regs !== 20'h43510 || {zero, carry} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL post_reset_exec: got regs=%h zc=%b expected regs=%h zc=%b",
               regs, {zero, carry}, 20'h43510, 2'b00);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  instr [4];
    logic [19:0] exp_regs [4];
    logic [1:0]  exp_flags [4];
    // ADD r1,r1 twice ; SUB r3,r3 ; SUB r0,r4
    instr = '{8'h89, 8'h89, 8'hDB, 8'hC4};
    exp_regs = '{20'h43520, 20'h43540, 20'h40540, 20'h4054C};
    exp_flags = '{2'b00, 2'b00, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      exec(instr[i], 1'b1, 1'b1);
      checks++;
      if (regs !== exp_regs[i] || {zero, carry} !== exp_flags[i]) begin
        failures++;
        $display("[TB] FAIL back_to_back step %0d (sig=%h): got regs=%h zc=%b expected regs=%h zc=%b",
                 i, instr[i], regs, {zero, carry}, exp_regs[i], exp_flags[i]);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    sig       = 8'h00;
    sig_valid = 1'b0;
    test_reset();
    test_sequence();
    test_wrap_borrow();
    test_out_of_range();
    test_valid_and_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
